// File: rtl/tx_afu_buffer.sv
// tx_afu_buffer: per-sub-AFU CCI-P Tx elastic buffer.
// c0 and c1 requests go into independent FIFOs that drain in order when the
// downstream leg is not almost full. The buffered FIFOs absorb requests issued
// after out_cX_almFull asserts. c2 (MMIO read responses) is a registered
// pass-through that is never throttled.
// Optional feature: define TX_AFU_BUFFER_BYPASS_EN to let an entry skip an
// empty FIFO and load the output register directly (1-cycle latency).

package tx_afu_buffer_pkg;
  localparam int C0_HDR_W  = 74;
  localparam int C1_HDR_W  = 80;
  localparam int CL_DATA_W = 512;
  localparam int C2_HDR_W  = 9;
  localparam int C2_DATA_W = 64;

  typedef struct packed {
    logic [C0_HDR_W-1:0]  hdr;
    logic                 valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [C1_HDR_W-1:0]  hdr;
    logic [CL_DATA_W-1:0] data;
    logic                 valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [C2_HDR_W-1:0]  hdr;
    logic                 mmioRdValid;
    logic [C2_DATA_W-1:0] data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
endpackage

// One buffered channel: FIFO in block RAM, registered read into the output
// register, registered almost-full and sticky overflow flags.
module tx_afu_buffer_chan #(
  parameter int WIDTH         = 8,
  parameter int DEPTH_LOG2    = 6,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_almfull,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_almfull,
  output logic             overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMFULL_THR = CNT_W'(DEPTH - ALMFULL_SLACK);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      rd_data_q;

  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic                  valid_q, valid_d;
  logic                  almfull_q, almfull_d;
  logic                  overflow_q, overflow_d;

  logic                  pop;
  logic                  byp;
  logic                  wr_en;
  logic                  drop;

  // Push/pop decisions, occupancy and flag next-state.
  always_comb begin
    pop = (count_q != '0) && !in_almfull;
`ifdef TX_AFU_BUFFER_BYPASS_EN
    byp = (count_q == '0) && in_valid && !in_almfull;
`else
    byp = 1'b0;
`endif
    // A full FIFO still accepts a write when the head leaves the same cycle.
    wr_en = in_valid && !byp && ((count_q != FULL_CNT) || pop);
    drop  = in_valid && !byp && (count_q == FULL_CNT) && !pop;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    wr_ptr_d   = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    valid_d    = pop || byp;
    almfull_d  = (count_d >= ALMFULL_THR);
    overflow_d = overflow_q || drop;
  end

  // Control state; reset flushes the FIFO by zeroing pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      almfull_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      almfull_q  <= almfull_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array with registered read; read-first so a full push+pop sees the old head.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in_data;
    end
    if (pop) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

`ifdef TX_AFU_BUFFER_BYPASS_EN
  logic [WIDTH-1:0] byp_data_q, byp_data_d;
  logic             sel_byp_q, sel_byp_d;

  // Bypass capture register and the select that remembers which source was loaded last.
  always_comb begin
    byp_data_d = byp ? in_data : byp_data_q;
    sel_byp_d  = sel_byp_q;
    if (byp) begin
      sel_byp_d = 1'b1;
    end else if (pop) begin
      sel_byp_d = 1'b0;
    end
  end

  // Bypass registers; the data register needs no reset since valid gates it.
  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
    if (reset) begin
      sel_byp_q <= 1'b0;
    end else begin
      sel_byp_q <= sel_byp_d;
    end
  end

  assign out_data = sel_byp_q ? byp_data_q : rd_data_q;
`else
  assign out_data = rd_data_q;
`endif

  assign out_valid   = valid_q;
  assign out_almfull = almfull_q;
  assign overflow    = overflow_q;
endmodule

module tx_afu_buffer
  import tx_afu_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2    = 6,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  t_if_ccip_Tx in,
  output t_if_ccip_Tx out,
  input  logic        in_c0_almFull,
  input  logic        in_c1_almFull,
  output logic        out_c0_almFull,
  output logic        out_c1_almFull,
  output logic [1:0]  overflow
);
  localparam int C1_W = C1_HDR_W + CL_DATA_W;

  logic                 c0_valid;
  logic [C0_HDR_W-1:0]  c0_hdr;
  logic                 c1_valid;
  logic [C1_W-1:0]      c1_entry;

  logic                 c2_valid_q, c2_valid_d;
  logic [C2_HDR_W-1:0]  c2_hdr_q, c2_hdr_d;
  logic [C2_DATA_W-1:0] c2_data_q, c2_data_d;

  tx_afu_buffer_chan #(
    .WIDTH         (C0_HDR_W),
    .DEPTH_LOG2    (DEPTH_LOG2),
    .ALMFULL_SLACK (ALMFULL_SLACK)
  ) u_c0 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in.c0.valid),
    .in_data     (in.c0.hdr),
    .in_almfull  (in_c0_almFull),
    .out_valid   (c0_valid),
    .out_data    (c0_hdr),
    .out_almfull (out_c0_almFull),
    .overflow    (overflow[0])
  );

  tx_afu_buffer_chan #(
    .WIDTH         (C1_W),
    .DEPTH_LOG2    (DEPTH_LOG2),
    .ALMFULL_SLACK (ALMFULL_SLACK)
  ) u_c1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in.c1.valid),
    .in_data     ({in.c1.hdr, in.c1.data}),
    .in_almfull  (in_c1_almFull),
    .out_valid   (c1_valid),
    .out_data    (c1_entry),
    .out_almfull (out_c1_almFull),
    .overflow    (overflow[1])
  );

  // c2 pass-through: payload only captured with a valid response, otherwise held.
  always_comb begin
    c2_valid_d = in.c2.mmioRdValid;
    c2_hdr_d   = in.c2.mmioRdValid ? in.c2.hdr  : c2_hdr_q;
    c2_data_d  = in.c2.mmioRdValid ? in.c2.data : c2_data_q;
  end

  // c2 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      c2_valid_q <= 1'b0;
      c2_hdr_q   <= '0;
      c2_data_q  <= '0;
    end else begin
      c2_valid_q <= c2_valid_d;
      c2_hdr_q   <= c2_hdr_d;
      c2_data_q  <= c2_data_d;
    end
  end

  // Reassemble the outgoing Tx bundle.
  always_comb begin
    out                = '0;
    out.c0.valid       = c0_valid;
    out.c0.hdr         = c0_hdr;
    out.c1.valid       = c1_valid;
    out.c1.hdr         = c1_entry[C1_W-1:CL_DATA_W];
    out.c1.data        = c1_entry[CL_DATA_W-1:0];
    out.c2.mmioRdValid = c2_valid_q;
    out.c2.hdr         = c2_hdr_q;
    out.c2.data        = c2_data_q;
  end
endmodule

// File: tb/tb_tx_afu_buffer.sv
// Randomized bench for tx_afu_buffer against a queue-based reference model.
// Honours TX_AFU_BUFFER_BYPASS_EN the same way the design does.
module tb_tx_afu_buffer;
  import tx_afu_buffer_pkg::*;

  localparam int DEPTH = 64;
  localparam int THR   = 56;

  logic        clk = 1'b0;
  logic        reset;
  t_if_ccip_Tx tx_in;
  t_if_ccip_Tx tx_out;
  logic        in_c0_af, in_c1_af;
  logic        out_c0_af, out_c1_af;
  logic [1:0]  overflow;

  int checks = 0;
  int errors = 0;
  int out0_cnt = 0;
  int out1_cnt = 0;

  // Reference model state
  logic [C0_HDR_W-1:0]           q0[$];
  logic [C1_HDR_W+CL_DATA_W-1:0] q1[$];
  logic                          exp_v0, exp_v1, exp_af0, exp_af1, exp_c2v;
  logic [C0_HDR_W-1:0]           exp_d0;
  logic [C1_HDR_W+CL_DATA_W-1:0] exp_d1;
  logic [1:0]                    exp_ovf;
  logic [C2_HDR_W-1:0]           exp_c2hdr;
  logic [C2_DATA_W-1:0]          exp_c2data;

  always #5 clk = ~clk;

  tx_afu_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .in             (tx_in),
    .out            (tx_out),
    .in_c0_almFull  (in_c0_af),
    .in_c1_almFull  (in_c1_af),
    .out_c0_almFull (out_c0_af),
    .out_c1_almFull (out_c1_af),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [639:0] rnd();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Drive one cycle of inputs with fresh random payloads.
  task automatic drive(input bit v0, input bit v1, input bit v2);
    logic [639:0] r;
    r = rnd(); tx_in.c0.hdr = r[C0_HDR_W-1:0];
    r = rnd(); tx_in.c1.hdr = r[C1_HDR_W-1:0];
    r = rnd(); tx_in.c1.data = r[CL_DATA_W-1:0];
    r = rnd(); tx_in.c2.hdr = r[C2_HDR_W-1:0];
    r = rnd(); tx_in.c2.data = r[C2_DATA_W-1:0];
    tx_in.c0.valid       = v0;
    tx_in.c1.valid       = v1;
    tx_in.c2.mmioRdValid = v2;
  endtask

  // Reference behaviour applied at each rising edge.
  task automatic model();
    logic byp0, byp1;
    logic [C1_HDR_W+CL_DATA_W-1:0] e1;
    if (reset) begin
      q0.delete(); q1.delete();
      exp_v0 = 0; exp_v1 = 0; exp_af0 = 0; exp_af1 = 0; exp_ovf = 2'b00; exp_c2v = 0;
    end else begin
      byp0 = 0; byp1 = 0;
`ifdef TX_AFU_BUFFER_BYPASS_EN
      byp0 = (q0.size() == 0) && tx_in.c0.valid && !in_c0_af;
      byp1 = (q1.size() == 0) && tx_in.c1.valid && !in_c1_af;
`endif
      exp_v0 = 0;
      if (q0.size() != 0 && !in_c0_af) begin exp_d0 = q0.pop_front(); exp_v0 = 1; end
      else if (byp0) begin exp_d0 = tx_in.c0.hdr; exp_v0 = 1; end
      if (tx_in.c0.valid && !byp0) begin
        if (q0.size() < DEPTH) q0.push_back(tx_in.c0.hdr); else exp_ovf[0] = 1;
      end
      exp_af0 = (q0.size() >= THR);

      e1 = {tx_in.c1.hdr, tx_in.c1.data};
      exp_v1 = 0;
      if (q1.size() != 0 && !in_c1_af) begin exp_d1 = q1.pop_front(); exp_v1 = 1; end
      else if (byp1) begin exp_d1 = e1; exp_v1 = 1; end
      if (tx_in.c1.valid && !byp1) begin
        if (q1.size() < DEPTH) q1.push_back(e1); else exp_ovf[1] = 1;
      end
      exp_af1 = (q1.size() >= THR);

      exp_c2v = tx_in.c2.mmioRdValid;
      if (exp_c2v) begin exp_c2hdr = tx_in.c2.hdr; exp_c2data = tx_in.c2.data; end
    end
  endtask

  task automatic compare();
    check("c0_valid", tx_out.c0.valid, exp_v0);
    if (exp_v0) check("c0_hdr", tx_out.c0.hdr, exp_d0);
    check("c1_valid", tx_out.c1.valid, exp_v1);
    if (exp_v1) check("c1_entry", {tx_out.c1.hdr, tx_out.c1.data}, exp_d1);
    check("c0_almfull", out_c0_af, exp_af0);
    check("c1_almfull", out_c1_af, exp_af1);
    check("overflow", overflow, exp_ovf);
    check("c2_valid", tx_out.c2.mmioRdValid, exp_c2v);
    if (exp_c2v) check("c2_payload", {tx_out.c2.hdr, tx_out.c2.data}, {exp_c2hdr, exp_c2data});
    if (tx_out.c0.valid) begin
      out0_cnt++;
      $display("c0 out #%0d hdr=%h", out0_cnt, tx_out.c0.hdr);
    end
    if (tx_out.c1.valid) begin
      out1_cnt++;
      $display("c1 out #%0d hdr=%h", out1_cnt, tx_out.c1.hdr);
    end
    if (tx_out.c2.mmioRdValid) $display("c2 out hdr=%h data=%h", tx_out.c2.hdr, tx_out.c2.data);
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit was_valid;
    tx_in = '0;
    in_c0_af = 0;
    in_c1_af = 0;
    do_reset();

    // Idle after reset
    drive(0, 0, 0);
    for (int i = 0; i < 10; i++) tick();

    // Single c1 write, check latency explicitly as well
    drive(0, 1, 0);
    tick();
`ifdef TX_AFU_BUFFER_BYPASS_EN
    check("t2_lat_first", tx_out.c1.valid, 1'b1);
`else
    check("t2_lat_first", tx_out.c1.valid, 1'b0);
`endif
    drive(0, 0, 0);
    tick();
`ifndef TX_AFU_BUFFER_BYPASS_EN
    check("t2_lat_second", tx_out.c1.valid, 1'b1);
`endif
    for (int i = 0; i < 3; i++) tick();

    // c0 almost-full threshold and slack, then in-order drain
    in_c0_af = 1;
    for (int i = 0; i < THR; i++) begin
      drive(1, 0, 0);
      tick();
      if (i == THR - 2) check("t3_af_before", out_c0_af, 1'b0);
    end
    check("t3_af_at56", out_c0_af, 1'b1);
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0); tick(); end
    check("t3_no_ovf", overflow[0], 1'b0);
    drive(0, 0, 0);
    in_c0_af = 0;
    base = out0_cnt;
    for (int i = 0; i < 70; i++) tick();
    check("t3_drain_cnt", out0_cnt - base, 64);
    check("t3_af_clear", out_c0_af, 1'b0);

    // c1 overflow on the 65th push
    in_c1_af = 1;
    for (int i = 0; i < 65; i++) begin drive(0, 1, 0); tick(); end
    check("t4_ovf", overflow[1], 1'b1);
    drive(0, 0, 0);
    in_c1_af = 0;
    base = out1_cnt;
    for (int i = 0; i < 70; i++) tick();
    check("t4_drain_cnt", out1_cnt - base, 64);
    check("t4_ovf_sticky", overflow[1], 1'b1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    in_c0_af = 1;
    for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 0); tick(); end
    in_c0_af = 0;
    for (int i = 0; i < 20; i++) begin drive(1, 0, 0); tick(); end
    check("t5_no_ovf", overflow[0], 1'b0);
    check("t5_af_full", out_c0_af, 1'b1);
    drive(0, 0, 0);
    for (int i = 0; i < 70; i++) tick();

    // c2 under backpressure, then reset with c0 queued
    in_c0_af = 1;
    in_c1_af = 1;
    for (int i = 0; i < 4; i++) begin drive(0, 0, i[0]); tick(); end
    drive(0, 0, 1);
    tick();
    check("t6_c2_valid", tx_out.c2.mmioRdValid, 1'b1);
    for (int i = 0; i < 30; i++) begin drive(1, 0, 0); tick(); end
    do_reset();
    in_c0_af = 0;
    in_c1_af = 0;
    base = out0_cnt;
    drive(0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_c0_out", out0_cnt - base, 0);
    check("t6_af_low", out_c0_af, 1'b0);

    // Random traffic with bursty backpressure and rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) in_c0_af = ~in_c0_af;
      if ($urandom_range(0, 15) == 0) in_c1_af = ~in_c1_af;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 0;
    in_c0_af = 0;
    in_c1_af = 0;
    drive(0, 0, 0);
    for (int i = 0; i < 70; i++) tick();
    was_valid = tx_out.c0.valid | tx_out.c1.valid;
    check("final_idle", was_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
